// File: rtl/rga_reg_decode.sv
// RGA register-address decoder: word address to one-hot select,
// plus a clk7-enabled trace copy of the last decoded access.
module rga_reg_decode #(
  parameter int NUM_REGS = 236
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk7_en,
  input  logic [8:1]          adr,
  output logic [NUM_REGS-1:0] reg_sel,
  output logic [7:0]          reg_idx,
  output logic                reg_hit
);

  localparam logic [8:0] LIMIT = 9'(NUM_REGS);

  logic [7:0] idx;
  logic       hit;

  assign idx = adr;
  assign hit = {1'b0, idx} < LIMIT;

  // Indices at or above NUM_REGS have no bit, so they decode to all zeros.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
    assign reg_sel[i] = (idx == 8'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_idx <= '0;
      reg_hit <= 1'b0;
    end else if (clk7_en) begin
      reg_idx <= idx;
      reg_hit <= hit;
    end
  end

endmodule

// File: tb/tb_rga_reg_decode.sv
// Randomised and directed bench for rga_reg_decode against
// an in-bench behavioural model.
module tb_rga_reg_decode;

  localparam int NUM_REGS = 236;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clk7_en;
  logic [8:1]          adr;
  logic [NUM_REGS-1:0] reg_sel;
  logic [7:0]          reg_idx;
  logic                reg_hit;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  logic [7:0] m_idx;
  logic       m_hit;

  rga_reg_decode #(.NUM_REGS(NUM_REGS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk7_en (clk7_en),
    .adr     (adr),
    .reg_sel (reg_sel),
    .reg_idx (reg_idx),
    .reg_hit (reg_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] exp_sel(input logic [7:0] a);
    logic [255:0] s;
    s = '0;
    if (int'(a) < NUM_REGS) s[a] = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: last enabled sample of the address, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = 8'd0;
      m_hit = 1'b0;
    end else if (clk7_en) begin
      m_idx = adr;
      m_hit = (int'(adr) < NUM_REGS);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_sel", 256'(reg_sel), exp_sel(adr));
      chk("cmp_idx", 256'(reg_idx), 256'(m_idx));
      chk("cmp_hit", 256'(reg_hit), 256'(m_hit));
    end
  end

  always @(adr or reg_sel)
    #0 assert ($countones(reg_sel) <= 1)
      else $error("reg_sel not one-hot");

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [8:0] ba [5] = '{9'h100, 9'h102, 9'h104, 9'h106, 9'h10C};
  int         bb [5] = '{128, 129, 130, 131, 134};

  initial begin
    rst_n   = 1'b0;
    clk7_en = 1'b0;
    adr     = '0;
    #1;
    chk("rst_idx", 256'(reg_idx), 256'd0);
    chk("rst_hit", 256'(reg_hit), 256'd0);
    #12 rst_n = 1'b1;
    run_cmp = 1;

    for (int i = 0; i < 256; i++) begin
      step();
      adr = 8'(i);
      clk7_en = 1'($urandom);
      #1;
      chk("sweep_bit", 256'(i < NUM_REGS ? reg_sel[i] : 1'b0),
          256'(i < NUM_REGS));
      chk("sweep_cnt", 256'($countones(reg_sel)), 256'(i < NUM_REGS));
    end

    for (int k = 0; k < 5; k++) begin
      adr = ba[k][8:1];
      #1;
      chk("bplcon_bit", 256'(reg_sel[bb[k]]), 256'd1);
      chk("bplcon_cnt", 256'($countones(reg_sel)), 256'd1);
    end

    step();
    adr = 8'h80;
    clk7_en = 1'b1;
    step();
    chk("en_idx", 256'(reg_idx), 256'h80);
    chk("en_hit", 256'(reg_hit), 256'd1);
    adr = 8'hF0;
    clk7_en = 1'b0;
    repeat (3) step();
    chk("hold_idx", 256'(reg_idx), 256'h80);
    chk("hold_hit", 256'(reg_hit), 256'd1);
    clk7_en = 1'b1;
    step();
    chk("f0_idx", 256'(reg_idx), 256'hF0);
    chk("f0_hit", 256'(reg_hit), 256'd0);

    adr = 8'h80;
    step();
    clk7_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_idx", 256'(reg_idx), 256'd0);
    chk("arst_hit", 256'(reg_hit), 256'd0);
    adr = 8'h12;
    #1;
    chk("arst_sel", 256'(reg_sel), 256'h1 << 18);

    clk7_en = 1'b1;
    adr = 8'h05;
    repeat (2) step();
    chk("rsthold_idx", 256'(reg_idx), 256'd0);
    chk("rsthold_hit", 256'(reg_hit), 256'd0);
    rst_n = 1'b1;
    step();
    chk("rel_idx", 256'(reg_idx), 256'd5);
    chk("rel_hit", 256'(reg_hit), 256'd1);

    adr = 8'h00;
    #1 chk("comb_0", 256'(reg_sel), 256'h1);
    adr = 8'hEB;
    #1 chk("comb_235", 256'(reg_sel), 256'h1 << 235);

    for (int n = 0; n < 3000; n++) begin
      step();
      adr = 8'($urandom);
      clk7_en = 1'($urandom);
      rst_n = ($urandom_range(0, 40) != 0);
    end
    step();
    run_cmp = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rga_reg_decode.md
Name: rga_reg_decode

Overview:
Register-address decoder for the chipset register bus (RGA). It converts the word address of a register into a one-hot select vector with one bit per register index. Downstream register blocks AND their select bit with the bus data strobe to latch register writes. It also keeps a registered copy of the last decoded access, sampled on the 7 MHz clock enable, for debug and tracing.

Parameters:
NUM_REGS, 236, width of the one-hot select vector and number of decodable register indices.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
clk7_en  input  1  7 MHz clock enable; registered outputs update only when it is high.
adr  input  8 (bits 8:1)  register word address on the bus (byte address 0x000-0x1FE, bit 0 implicit).
reg_sel  output  NUM_REGS  combinational one-hot select, bit i = register index i.
reg_idx  output  8  registered index of the last decoded address.
reg_hit  output  1  registered; 1 if the last sampled address mapped to a valid index.

Behaviour:
- Index mapping: index = adr[8:1], unsigned 0..255.
- Example indices: byte address 0x100 (BPLCON0) is index 128; 0x102 (BPLCON1) is 129; 0x104 (BPLCON2) is 130; 0x106 (BPLCON3) is 131; 0x10C (BPLCON4) is 134.
- reg_sel is purely combinational, with zero latency from adr.
  - If index < NUM_REGS: exactly bit [index] is 1 and all other bits are 0.
  - If index >= NUM_REGS (byte addresses 0x1D8-0x1FE with the default): reg_sel is all zeros.
- reg_sel never has more than one bit set. It is never X when adr is known.
- reg_sel does not depend on clk, rst_n or clk7_en.
- Registered outputs, on a rising clk edge with clk7_en = 1:
  - reg_idx <= adr[8:1].
  - reg_hit <= (adr[8:1] < NUM_REGS).
- With clk7_en = 0, reg_idx and reg_hit hold their values.
- Latency from adr to reg_idx / reg_hit is one enabled clock.
- Reset: rst_n low asynchronously forces reg_idx = 0 and reg_hit = 0, independent of clk.
  - Release is synchronous to clk: the first enabled edge after rst_n goes high loads the new values.
  - Reset asserted mid-operation clears the registered outputs immediately. reg_sel keeps tracking adr.
- If clk7_en is high on the same edge that rst_n is low, reset wins.
- NUM_REGS must be in 1..256. Bits at or above NUM_REGS do not exist.

Test Plan:
- Sweep adr[8:1] from 0 to 255 with all other inputs held. Check that reg_sel is one-hot at bit adr for 0..235 and all-zero for 236..255. Use $countones(reg_sel) <= 1 as a continuous assertion.
- Drive byte addresses 0x100, 0x102, 0x104, 0x106 and 0x10C. Check that reg_sel bits 128, 129, 130, 131 and 134 are set respectively, each with no other bit set.
- Hold clk7_en = 1 with adr[8:1] = 0x80 and apply one clock edge. Expect reg_idx = 0x80 and reg_hit = 1. Then set adr[8:1] = 0xF0 with clk7_en = 0 for 3 edges: reg_idx stays 0x80. Raise clk7_en for 1 edge: reg_idx = 0xF0 and reg_hit = 0.
- With reg_idx = 0x80 and reg_hit = 1, pulse rst_n low between clock edges. Expect reg_idx = 0 and reg_hit = 0 immediately, before the next edge, while reg_sel still follows adr.
- Hold rst_n low while clk7_en = 1 and adr[8:1] = 0x05 for 2 edges: outputs stay 0. Release rst_n: the next enabled edge gives reg_idx = 5 and reg_hit = 1.
- Change adr between clock edges. Check that reg_sel updates in the same delta/cycle with no clock dependency: byte address 0x000 gives bit 0, and byte address 0x1D6 gives bit 235.
